// File: rtl/game_state_ctrl_pkg.sv
//============================================================================
// Module  : game_pkg
// Purpose : Shared game types and geometry constants for the ghost, Pac-Man
//           and supervisor blocks.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    HIT     = 3'd2,
    RESPAWN = 3'd3,
    OVER    = 3'd4
  } game_state_t;

  localparam int COORD_W     = 10;
  localparam int NUM_GHOSTS  = 4;
  localparam int SPRITE_SIZE = 16;
  localparam int MAZE_X_MAX  = 639;
  localparam int MAZE_Y_MAX  = 479;

endpackage : game_pkg

`default_nettype wire

// File: rtl/game_state_ctrl_if.sv
//============================================================================
// Module  : game_state_ctrl_if
// Purpose : Sprite positions and control handshake between the game logic
//           and the supervisor.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

interface game_state_ctrl_if;
  logic [9:0]  PacX;
  logic [9:0]  PacY;
  logic [39:0] GhostX;
  logic [39:0] GhostY;
  logic        start_key;
  logic        pellets_done;
  logic [4:0]  counter;
  logic        start_game;
  logic        game_over;
  logic        win;
  logic [1:0]  lives;
  logic        respawn;

  modport master (
    output PacX, PacY, GhostX, GhostY, start_key, pellets_done,
    input  counter, start_game, game_over, win, lives, respawn
  );

  modport slave (
    input  PacX, PacY, GhostX, GhostY, start_key, pellets_done,
    output counter, start_game, game_over, win, lives, respawn
  );
endinterface : game_state_ctrl_if

`default_nettype wire

// File: rtl/game_state_ctrl_sprite_hit_detect.sv
//============================================================================
// Module  : sprite_hit_detect
// Purpose : Combinational overlap test between one ghost and Pac-Man.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module sprite_hit_detect
  import game_pkg::*;
#(
  parameter int HIT_DIST = 12
) (
  input  wire logic [COORD_W-1:0] ghost_x,
  input  wire logic [COORD_W-1:0] ghost_y,
  input  wire logic [COORD_W-1:0] pac_x,
  input  wire logic [COORD_W-1:0] pac_y,
  output logic                    hit
);

  localparam logic [COORD_W:0] c_hit_dist = HIT_DIST[COORD_W:0];

  logic [COORD_W:0] w_dx;
  logic [COORD_W:0] w_dy;
  logic [COORD_W:0] w_adx;
  logic [COORD_W:0] w_ady;

  // One extra bit keeps the two's-complement difference free of wrap.
  assign w_dx  = {1'b0, ghost_x} - {1'b0, pac_x};
  assign w_dy  = {1'b0, ghost_y} - {1'b0, pac_y};
  assign w_adx = w_dx[COORD_W] ? (~w_dx + 1'b1) : w_dx;
  assign w_ady = w_dy[COORD_W] ? (~w_dy + 1'b1) : w_dy;
  assign hit   = (w_adx < c_hit_dist) && (w_ady < c_hit_dist);

endmodule : sprite_hit_detect

`default_nettype wire

// File: rtl/game_state_ctrl.sv
//============================================================================
// Module  : game_state_ctrl
// Purpose : Frame-rate supervisor: collisions, lives/round FSM, LFSR.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module game_state_ctrl
  import game_pkg::*;
#(
  parameter int         HIT_DIST     = 12,
  parameter int         START_LIVES  = 3,
  parameter int         DEATH_FRAMES = 120,
  parameter logic [4:0] LFSR_SEED    = 5'b00001
) (
  input wire logic          frame_clk,
  input wire logic          Reset,
  game_state_ctrl_if.slave  bus
);

  localparam logic [1:0] c_lives_init = START_LIVES[1:0];
  localparam logic [7:0] c_timer_load = 8'(DEATH_FRAMES - 1);

  game_state_t r_state;
  game_state_t w_next_state;
  logic [1:0]  r_lives;
  logic [7:0]  r_timer;
  logic        r_win;
  logic [4:0]  r_counter;
  logic        r_key_q;
  logic        w_key_rise;
  logic [NUM_GHOSTS-1:0] w_hit;
  logic        w_hit_any;
  logic        w_start_game;
  logic        w_game_over;
  logic        w_respawn;

  for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
    sprite_hit_detect #(.HIT_DIST(HIT_DIST)) u_hit (
      .ghost_x (bus.GhostX[COORD_W*gi +: COORD_W]),
      .ghost_y (bus.GhostY[COORD_W*gi +: COORD_W]),
      .pac_x   (bus.PacX),
      .pac_y   (bus.PacY),
      .hit     (w_hit[gi])
    );
  end

  assign w_hit_any  = |w_hit;
  assign w_key_rise = bus.start_key & ~r_key_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_key_rise) w_next_state = PLAY;
      PLAY: begin
        if (bus.pellets_done)  w_next_state = OVER;
        else if (w_hit_any)    w_next_state = HIT;
      end
      HIT:     if (r_timer == 8'd0) w_next_state = (r_lives == 2'd0) ? OVER : RESPAWN;
      RESPAWN: w_next_state = PLAY;
      OVER:    if (w_key_rise) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_start_game = 1'b0;
    w_game_over  = 1'b0;
    w_respawn    = 1'b0;
    case (r_state)
      PLAY:    w_start_game = 1'b1;
      OVER:    w_game_over  = 1'b1;
      RESPAWN: w_respawn    = 1'b1;
      default: ;
    endcase
  end

  // Lives only drop on PLAY->HIT; the zero test in HIT keeps them from wrapping.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_lives   <= c_lives_init;
      r_timer   <= 8'd0;
      r_win     <= 1'b0;
      r_counter <= LFSR_SEED;
      r_key_q   <= 1'b0;
    end else begin
      r_counter <= {r_counter[3:0], r_counter[4] ^ r_counter[2]};
      r_key_q   <= bus.start_key;
      case (r_state)
        PLAY: begin
          if (bus.pellets_done) begin
            r_win <= 1'b1;
          end else if (w_hit_any) begin
            r_lives <= r_lives - 1'b1;
            r_timer <= c_timer_load;
          end
        end
        HIT:  if (r_timer != 8'd0) r_timer <= r_timer - 1'b1;
        OVER: begin
          if (w_key_rise) begin
            r_lives <= c_lives_init;
            r_win   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.counter    = r_counter;
  assign bus.start_game = w_start_game;
  assign bus.game_over  = w_game_over;
  assign bus.win        = r_win;
  assign bus.lives      = r_lives;
  assign bus.respawn    = w_respawn;

endmodule : game_state_ctrl

`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
//============================================================================
// Module  : tb_game_state_ctrl
// Purpose : Directed and randomized checks of game_state_ctrl against a
//           behavioural game model.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_game_state_ctrl;

  localparam int HIT_DIST     = 12;
  localparam int START_LIVES  = 3;
  localparam int DEATH_FRAMES = 120;

  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_RESPAWN = 3, M_OVER = 4;
  localparam logic [10:0] RESET_VEC = {5'h01, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};

  logic frame_clk = 1'b0;
  logic Reset;

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .HIT_DIST     (HIT_DIST),
    .START_LIVES  (START_LIVES),
    .DEATH_FRAMES (DEATH_FRAMES),
    .LFSR_SEED    (5'b00001)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: mode, lives, frames left in the death freeze, win flag, LFSR.
  int m_mode, m_lives, m_left, m_lfsr;
  bit m_win, m_prev_key;

  task automatic model_reset();
    m_mode = M_IDLE; m_lives = START_LIVES; m_left = 0;
    m_win = 1'b0; m_prev_key = 1'b0; m_lfsr = 1;
  endtask

  function automatic bit touching(int gx, int gy, int px, int py);
    int dx = gx - px;
    int dy = gy - py;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx < HIT_DIST) && (dy < HIT_DIST);
  endfunction

  function automatic bit any_touch();
    bit t = 1'b0;
    for (int i = 0; i < 4; i++)
      if (touching(int'(bus.GhostX[10*i +: 10]), int'(bus.GhostY[10*i +: 10]),
                   int'(bus.PacX), int'(bus.PacY))) t = 1'b1;
    return t;
  endfunction

  task automatic model_step();
    bit rise  = bus.start_key && !m_prev_key;
    bit touch = any_touch();
    m_prev_key = bus.start_key;
    m_lfsr = ((m_lfsr << 1) & 31) | (((m_lfsr >> 4) ^ (m_lfsr >> 2)) & 1);
    case (m_mode)
      M_IDLE:    if (rise) m_mode = M_PLAY;
      M_PLAY: begin
        if (bus.pellets_done) begin m_mode = M_OVER; m_win = 1'b1; end
        else if (touch) begin m_mode = M_HIT; m_lives--; m_left = DEATH_FRAMES; end
      end
      M_HIT: begin
        m_left--;
        if (m_left == 0) m_mode = (m_lives == 0) ? M_OVER : M_RESPAWN;
      end
      M_RESPAWN: m_mode = M_PLAY;
      M_OVER: if (rise) begin m_mode = M_IDLE; m_lives = START_LIVES; m_win = 1'b0; end
      default: ;
    endcase
  endtask

  function automatic logic [10:0] outs();
    return {bus.counter, bus.start_game, bus.game_over, bus.win, bus.lives, bus.respawn};
  endfunction

  function automatic logic [10:0] expv();
    return {5'(m_lfsr), m_mode == M_PLAY, m_mode == M_OVER, m_win, 2'(m_lives),
            m_mode == M_RESPAWN};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
    check("model", 32'(outs()), 32'(expv()));
  endtask

  task automatic put_ghost(int i, int x, int y);
    bus.GhostX[10*i +: 10] = 10'(x);
    bus.GhostY[10*i +: 10] = 10'(y);
  endtask

  task automatic park();
    for (int i = 0; i < 4; i++) put_ghost(i, 500 + 30*i, 400);
  endtask

  task automatic async_reset_pulse(string tag);
    #3 Reset = 1'b1;
    #1;
    model_reset();
    check(tag, 32'(outs()), 32'(RESET_VEC));
    #2 Reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] lfsr_ref [4];
    lfsr_ref = '{5'h02, 5'h04, 5'h09, 5'h12};

    Reset = 1'b1;
    bus.PacX = 10'd100; bus.PacY = 10'd100;
    bus.start_key = 1'b0; bus.pellets_done = 1'b0;
    park();
    model_reset();
    #12;
    check("reset_vec", 32'(outs()), 32'(RESET_VEC));
    @(negedge frame_clk);
    Reset = 1'b0;

    // LFSR sequence and period while idle
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i <= 4) check("lfsr_seq", 32'(bus.counter), 32'(lfsr_ref[i-1]));
      check("lfsr_nonzero", 32'(bus.counter != 5'd0), 32'd1);
    end
    check("lfsr_period", 32'(bus.counter), 32'h01);

    // Start, boundary no-hit, then hit by ghost 2
    bus.start_key = 1'b1; tick(); bus.start_key = 1'b0;
    check("start_play", 32'(bus.start_game), 32'd1);
    put_ghost(0, 112, 100); tick();
    check("no_hit_dx12", 32'(bus.start_game), 32'd1);
    park(); put_ghost(2, 111, 90); tick();
    check("hit_lives", 32'({bus.start_game, bus.lives}), 32'({1'b0, 2'd2}));
    for (int f = 1; f < DEATH_FRAMES; f++) begin
      put_ghost(0, 95 + $urandom_range(0, 10), 95 + $urandom_range(0, 10));
      bus.start_key = 1'($urandom_range(0, 1));
      tick();
      check("hit_frozen", 32'({bus.start_game, bus.respawn}), 32'd0);
    end
    park(); bus.start_key = 1'b0;
    tick();
    check("respawn_pulse", 32'(bus.respawn), 32'd1);
    tick();
    check("back_to_play", 32'({bus.respawn, bus.start_game}), 32'b01);

    // dx = -11 hits
    put_ghost(1, 89, 100); tick();
    check("hit_dx_m11", 32'({bus.start_game, bus.lives}), 32'({1'b0, 2'd1}));
    park();
    for (int f = 0; f < DEATH_FRAMES + 1; f++) tick();
    check("play_again", 32'(bus.start_game), 32'd1);

    // Last life, key held through the transition to OVER
    put_ghost(3, 105, 95); tick(); park();
    check("last_life", 32'(bus.lives), 32'd0);
    for (int f = 1; f < DEATH_FRAMES; f++) begin
      if (f == 50) bus.start_key = 1'b1;
      tick();
    end
    tick();
    check("over_lost", 32'({bus.game_over, bus.win, bus.start_game}), 32'b100);
    for (int f = 0; f < 5; f++) tick();
    check("held_key_stays", 32'(bus.game_over), 32'd1);
    bus.start_key = 1'b0; tick();
    check("release_stays", 32'(bus.game_over), 32'd1);
    bus.start_key = 1'b1; tick(); bus.start_key = 1'b0;
    check("restart_idle", 32'({bus.game_over, bus.lives, bus.start_game}), 32'({1'b0, 2'd3, 1'b0}));
    tick();

    // Win beats a same-frame collision
    bus.start_key = 1'b1; tick(); bus.start_key = 1'b0; tick();
    put_ghost(0, 100, 100); bus.pellets_done = 1'b1; tick();
    check("win_priority", 32'({bus.game_over, bus.win, bus.lives}), 32'({1'b1, 1'b1, 2'd3}));
    bus.pellets_done = 1'b0; park();
    bus.start_key = 1'b1; tick(); bus.start_key = 1'b0;
    check("win_cleared", 32'({bus.game_over, bus.win}), 32'd0);
    tick();

    // Randomized play
    for (int f = 0; f < 1500; f++) begin
      bus.PacX = 10'($urandom_range(0, 639));
      bus.PacY = 10'($urandom_range(0, 479));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0)
          put_ghost(i, int'(bus.PacX) + 20 + $urandom_range(0, 30) - 35,
                       int'(bus.PacY) + 20 + $urandom_range(0, 30) - 35);
        else
          put_ghost(i, $urandom_range(0, 639), $urandom_range(0, 479));
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.GhostX[10*i +: 10] > 10'd1000) bus.GhostX[10*i +: 10] = 10'd0;
        if (bus.GhostY[10*i +: 10] > 10'd1000) bus.GhostY[10*i +: 10] = 10'd0;
      end
      bus.start_key    = ($urandom_range(0, 7) == 0);
      bus.pellets_done = ($urandom_range(0, 199) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a death freeze
    bus.start_key = 1'b0; bus.pellets_done = 1'b0; park();
    bus.PacX = 10'd100; bus.PacY = 10'd100;
    async_reset_pulse("sync_point_reset");
    bus.start_key = 1'b1; tick(); bus.start_key = 1'b0; tick();
    put_ghost(0, 100, 100); tick(); park();
    check("hit_before_reset", 32'({bus.start_game, bus.lives}), 32'({1'b0, 2'd2}));
    for (int f = 0; f < 7; f++) tick();
    async_reset_pulse("async_reset_mid_hit");
    for (int f = 0; f < 3; f++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_game_state_ctrl

`default_nettype wire
